// File: rtl/neuron_frame_sequencer.sv
// neuron_frame_sequencer
//   Feeds a combinational neuron (x1/x2/x3 -> y) from a serial valid/ready
//   sample stream and collects its result on a registered valid/ready port.
//   Samples are grouped into 3-sample frames. A completed frame is held on
//   x1..x3 for SETTLE_CYCLES edges, and then y is captured.
//
// Parameters
//   DATA_W        sample / result width (two's complement, passed bit-exact)
//   SETTLE_CYCLES edges from frame completion to capture of y (>= 1)
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   s_valid/s_ready       input sample handshake
//   s_data, s_sof         sample and start-of-frame marker
//   x1, x2, x3            registered neuron inputs
//   y                     combinational neuron output
//   m_valid/m_ready       result handshake, m_data = captured y
//   sof_err               one-cycle pulse on a frame-sync error
//   err_cnt               saturating sync-error count
//   frame_cnt             wrapping count of handed-off results
module neuron_frame_sequencer #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] y,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              sof_err,
    output logic [7:0]        err_cnt,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   x1_q, x1_d;
    logic [DATA_W-1:0]   x2_q, x2_d;
    logic [DATA_W-1:0]   x3_q, x3_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                sof_err_q, sof_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic s_ready_c;
    logic accept;
    logic handoff;
    logic sync_err;
    logic frame_done;

    // In OUT the result is already captured, so the next frame may fill;
    // only its completing sample has to wait until the slot is freed.
    always_comb begin
        s_ready_c = 1'b0;
        case (state_q)
            FILL:    s_ready_c = 1'b1;
            SETTLE:  s_ready_c = 1'b0;
            OUT:     s_ready_c = (idx_q != 2'd2) || m_ready;
            default: s_ready_c = 1'b0;
        endcase
    end

    assign accept     = s_valid && s_ready_c;
    assign handoff    = m_valid_q && m_ready;
    assign sync_err   = accept && s_sof && (idx_q != 2'd0);
    assign frame_done = accept && !sync_err && (idx_q == 2'd2);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;
        cnt_d       = cnt_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        sof_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;

        // Sample write path. A misplaced SOF restarts the frame at x1;
        // the stale x2/x3 are simply overwritten by the new frame later.
        if (accept) begin
            if (sync_err) begin
                x1_d      = s_data;
                idx_d     = 2'd1;
                sof_err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                case (idx_q)
                    2'd1: begin
                        x2_d  = s_data;
                        idx_d = 2'd2;
                    end
                    2'd2: begin
                        x3_d  = s_data;
                        idx_d = 2'd0;
                        cnt_d = CNT_LOAD;
                    end
                    default: begin
                        x1_d  = s_data;
                        idx_d = 2'd1;
                    end
                endcase
            end
        end

        if (handoff) begin
            m_valid_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            FILL: begin
                if (frame_done) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    m_data_d  = y;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                // Completing a frame here requires m_ready, so it always
                // coincides with the handoff of the pending result.
                if (frame_done) begin
                    state_d = SETTLE;
                end else if (handoff) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= 2'd0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            cnt_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            sof_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            cnt_q       <= cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            sof_err_q   <= sof_err_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready   = s_ready_c;
    assign x1        = x1_q;
    assign x2        = x2_q;
    assign x3        = x3_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign sof_err   = sof_err_q;
    assign err_cnt   = err_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_neuron_frame_sequencer.sv
// Bench for neuron_frame_sequencer. Two instances (settle 1 and settle 4)
// share one input stream; each is compared every cycle against its own
// frame/queue-level reference model.
module tb_neuron_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s_valid, s_sof, m_ready;
    logic [7:0] s_data, y;

    logic       s_ready [2];
    logic       m_valid [2];
    logic       sof_err [2];
    logic [7:0] x1 [2];
    logic [7:0] x2 [2];
    logic [7:0] x3 [2];
    logic [7:0] m_data [2];
    logic [7:0] err_cnt [2];
    logic [15:0] frame_cnt [2];

    neuron_frame_sequencer #(.DATA_W(8), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_data(s_data), .s_sof(s_sof), .x1(x1[0]), .x2(x2[0]), .x3(x3[0]),
        .y(y), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .sof_err(sof_err[0]), .err_cnt(err_cnt[0]), .frame_cnt(frame_cnt[0])
    );

    neuron_frame_sequencer #(.DATA_W(8), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_data(s_data), .s_sof(s_sof), .x1(x1[1]), .x2(x2[1]), .x3(x3[1]),
        .y(y), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .sof_err(sof_err[1]), .err_cnt(err_cnt[1]), .frame_cnt(frame_cnt[1])
    );

    int total = 0;
    int bad   = 0;

    // reference model: slot counter, frame contents, remaining settle
    // edges (-1 = none in flight), pending result and counters
    int         settle [2] = '{1, 4};
    int         midx [2];
    int         mwait [2];
    bit         mpend [2];
    bit         merr [2];
    int         mecnt [2];
    int         mfcnt [2];
    logic [7:0] mx [2][3];
    logic [7:0] mres [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int i);
        if (mwait[i] >= 0) return 1'b0;
        if (mpend[i]) return (midx[i] != 2) || m_ready;
        return 1'b1;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            midx[i] = 0; mwait[i] = -1; mpend[i] = 0; merr[i] = 0;
            mecnt[i] = 0; mfcnt[i] = 0; mres[i] = 8'h00;
            for (int k = 0; k < 3; k++) mx[i][k] = 8'h00;
        end
    endtask

    task automatic mstep();
        for (int i = 0; i < 2; i++) begin
            bit acc, hs, cap;
            acc = s_valid && exp_rdy(i);
            hs  = mpend[i] && m_ready;
            cap = (mwait[i] == 0);
            merr[i] = 0;
            if (mwait[i] >= 0) mwait[i]--;
            if (cap) mres[i] = y;
            if (acc) begin
                if (s_sof && midx[i] != 0) begin
                    merr[i]  = 1;
                    mx[i][0] = s_data;
                    midx[i]  = 1;
                    if (mecnt[i] < 255) mecnt[i]++;
                end else begin
                    mx[i][midx[i]] = s_data;
                    midx[i]++;
                    if (midx[i] == 3) begin
                        midx[i]  = 0;
                        mwait[i] = settle[i] - 1;
                    end
                end
            end
            if (hs) begin
                mpend[i] = 0;
                mfcnt[i] = (mfcnt[i] + 1) % 65536;
            end
            if (cap) mpend[i] = 1;
        end
    endtask

    task automatic chk_outs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("x1[%0d]", i), 32'(x1[i]), 32'(mx[i][0]));
            chk($sformatf("x2[%0d]", i), 32'(x2[i]), 32'(mx[i][1]));
            chk($sformatf("x3[%0d]", i), 32'(x3[i]), 32'(mx[i][2]));
            chk($sformatf("m_valid[%0d]", i), 32'(m_valid[i]), 32'(mpend[i]));
            chk($sformatf("m_data[%0d]", i), 32'(m_data[i]), 32'(mres[i]));
            chk($sformatf("sof_err[%0d]", i), 32'(sof_err[i]), 32'(merr[i]));
            chk($sformatf("err_cnt[%0d]", i), 32'(err_cnt[i]), 32'(mecnt[i]));
            chk($sformatf("frame_cnt[%0d]", i), 32'(frame_cnt[i]), 32'(mfcnt[i]));
        end
    endtask

    task automatic chk_rdy();
        for (int i = 0; i < 2; i++)
            chk($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(exp_rdy(i)));
    endtask

    // one clock: drive, check combinational ready, clock, check registers
    task automatic cyc(input bit v, input logic [7:0] d, input bit sof, input bit mr);
        s_valid = v; s_data = d; s_sof = sof; m_ready = mr;
        y = 8'($urandom);
        #1;
        chk_rdy();
        @(posedge clk);
        mstep();
        #1;
        chk_outs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mreset();
        chk_outs();
        chk_rdy();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pv, ps, pm;
        s_valid = 0; s_data = 0; s_sof = 0; m_ready = 0; y = 0;
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // basic frame 5, -3, 7
        cyc(1, 8'd5, 1, 1);
        cyc(1, 8'hFD, 0, 1);
        cyc(1, 8'd7, 0, 1);
        chk("basic_x1", 32'(x1[0]), 32'd5);
        chk("basic_x2", 32'(x2[0]), 32'hFD);
        chk("basic_x3", 32'(x3[0]), 32'd7);
        for (int k = 0; k < 8; k++) cyc(0, 8'h00, 0, 1);
        chk("basic_frame_cnt", 32'(frame_cnt[0]), 32'd1);

        // backpressure: full frame then next frame pushes against m_ready=0
        for (int k = 0; k < 14; k++) cyc(1, 8'(k + 40), 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 8'(k + 60), 0, 1);
        for (int k = 0; k < 8; k++) cyc(0, 8'h00, 0, 1);

        // reset mid-frame after two accepts, then a fresh frame
        cyc(1, 8'd1, 1, 1);
        cyc(1, 8'd2, 0, 1);
        do_reset();
        cyc(1, 8'd11, 0, 1);
        cyc(1, 8'd12, 0, 1);
        cyc(1, 8'd13, 0, 1);
        chk("fresh_x1", 32'(x1[1]), 32'd11);
        for (int k = 0; k < 6; k++) cyc(0, 8'h00, 0, 1);

        // extremes pass bit-exact
        cyc(1, 8'h80, 1, 1);
        cyc(1, 8'h7F, 0, 1);
        cyc(1, 8'hFF, 0, 1);
        chk("ext_x1", 32'(x1[0]), 32'h80);
        chk("ext_x2", 32'(x2[0]), 32'h7F);
        chk("ext_x3", 32'(x3[0]), 32'hFF);
        for (int k = 0; k < 6; k++) cyc(0, 8'h00, 0, 1);

        // sync errors: 10, 20, 30(sof), then 299 x (10, 30(sof))
        do_reset();
        cyc(1, 8'd10, 0, 1);
        cyc(1, 8'd20, 0, 1);
        cyc(1, 8'd30, 1, 1);
        chk("sync_pulse", 32'(sof_err[0]), 32'd1);
        chk("sync_cnt1", 32'(err_cnt[1]), 32'd1);
        chk("sync_x1", 32'(x1[0]), 32'd30);
        cyc(0, 8'd0, 0, 1);
        chk("sync_pulse_end", 32'(sof_err[0]), 32'd0);
        for (int k = 0; k < 299; k++) begin
            cyc(1, 8'd10, 0, 1);
            cyc(1, 8'd30, 1, 1);
        end
        chk("sync_sat0", 32'(err_cnt[0]), 32'd255);
        chk("sync_sat1", 32'(err_cnt[1]), 32'd255);
        chk("sync_noresult", 32'(m_valid[0]), 32'd0);

        // randomized phases with varying valid / sof / ready densities
        for (int ph = 0; ph < 12; ph++) begin
            pv = $urandom_range(30, 100);
            ps = $urandom_range(0, 40);
            pm = $urandom_range(10, 100);
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                cyc($urandom_range(0, 99) < pv, 8'($urandom),
                    $urandom_range(0, 99) < ps, $urandom_range(0, 99) < pm);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_frame_sequencer.md
# neuron_frame_sequencer

Upstream feeder and result collector for the combinational `artificial_neuron` (signed 8-bit Mitchell-multiplier neuron, inputs `x1`/`x2`/`x3`, output `y`). It accepts a serial valid/ready stream of signed samples and assembles them into 3-sample frames. Each frame is held stable on the neuron inputs for a fixed settle window, then the neuron output is captured into a registered valid/ready result port. Frame-sync errors are flagged and counted, and completed frames are counted.

## Interface

Parameters:

- `DATA_W`, default 8: sample and result width, two's complement.
- `SETTLE_CYCLES`, default 1: clock edges between frame completion and capture of `y`. Legal range is at least 1.

Ports:

- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: an input sample is offered.
- `s_ready`, output, 1: the block accepts the sample this cycle.
- `s_data`, input, `DATA_W`: signed input sample.
- `s_sof`, input, 1: marks the offered sample as the first of a frame (`x1`).
- `x1`, `x2`, `x3`, output, `DATA_W` each: registered neuron inputs.
- `y`, input, `DATA_W`: combinational neuron output.
- `m_valid`, output, 1: a result is pending.
- `m_ready`, input, 1: the downstream consumer accepts the result.
- `m_data`, output, `DATA_W`: captured `y`.
- `sof_err`, output, 1: one-cycle pulse on a frame-sync error.
- `err_cnt`, output, 8: saturating count of frame-sync errors.
- `frame_cnt`, output, 16: wrapping count of results handed off.

## Operation

- **Handshakes.**
  - Accept: `s_valid && s_ready` at a rising edge.
  - Handoff: `m_valid && m_ready` at a rising edge.
- **State machine:** states FILL, SETTLE, OUT. A 2-bit index `idx` (0..2) tracks the next frame slot.
- **FILL.**
  - `s_ready=1`.
  - An accepted sample is written to `x[idx+1]` and `idx` increments.
  - Accepting at `idx==2` writes `x3`, sets `idx=0`, loads settle counter with `SETTLE_CYCLES-1`, and moves to SETTLE.
- **SETTLE.**
  - `s_ready=0`; `x1..x3` are frozen.
  - On each edge: if the counter is 0, `m_data<=y`, `m_valid<=1`, go to OUT; otherwise decrement.
- **OUT.**
  - `m_valid=1`; `m_data` is stable until handoff.
  - Samples for the next frame may be accepted, because `y` is already captured.
  - `s_ready = (idx!=2) || m_ready`.
  - On handoff: `m_valid<=0` and `frame_cnt` increments.
  - If the third sample is accepted on the same edge as handoff, go to SETTLE. Otherwise, on handoff go to FILL.
  - Without handoff, stay in OUT.
- **Sync.**
  - `s_sof` on an accepted sample with `idx==0` is normal.
  - `s_sof` on an accepted sample with `idx!=0` is an error:
    - the partial frame is discarded;
    - the sample is written to `x1` and `idx<=1`;
    - `sof_err` pulses high for exactly the following cycle;
    - `err_cnt` increments, saturating at 255.
  - A frame without `s_sof` on its first sample is legal.
- **Arithmetic.** No arithmetic on sample values. Data pass through bit-exact, and `m_data` is `y` unmodified.

## Timing

- **Reset values** (asynchronous on `rst_n` low, regardless of state or mid-frame):
  - state FILL, `idx=0`;
  - `x1=x2=x3=0`, `m_data=0`, `m_valid=0`;
  - `sof_err=0`, `err_cnt=0`, `frame_cnt=0`;
  - settle counter 0;
  - `s_ready=1` while in reset and immediately after release.
- **Reset mid-operation:** a partial frame or pending result is dropped with no handoff. Reset during SETTLE never produces a result.
- **Latency:** third sample accepted at edge k gives `m_valid` high after edge k+`SETTLE_CYCLES`. `x1..x3` update on the acceptance edge and are constant from edge k to the capture edge.
- **Throughput:** with `s_valid=1` and `m_ready=1` continuously, one result per 3+`SETTLE_CYCLES` cycles.
- **`frame_cnt`:** wraps from 0xFFFF to 0.
- **Outputs:** `s_ready` is combinational from state, `idx` and `m_ready`. All other outputs are registered.

## Test plan

- **Reset:** hold `rst_n=0` mid-frame after 2 accepts → all outputs at reset values; after release, the next 3 samples form a fresh frame.
- **Basic frame:** stream 5, -3, 7 with `s_sof` on 5, `m_ready=1`, `SETTLE_CYCLES=1` → `x1=5`, `x2=-3`, `x3=7` after the third accept. `m_valid` rises one edge later with `m_data` equal to `y` at that edge. `frame_cnt=1` after handoff.
- **Backpressure:** `m_ready=0` → `m_valid` held and `m_data` stable. Next-frame samples 1 and 2 are accepted, and the third is refused (`s_ready=0`). Raise `m_ready` → handoff and third accept on the same edge, then SETTLE.
- **Sync error:** accept 10, 20, then 30 with `s_sof` → `sof_err` pulses one cycle, `err_cnt=1`, `x1=30`, `idx=1`, no result produced. Repeat 300 times → `err_cnt=255`.
- **Settle:** `SETTLE_CYCLES=4` → `s_ready=0` for exactly 4 cycles after the third accept, and `x1..x3` are unchanged during that window.
- **Extremes and wrap:** frames of -128, 127, -1 pass bit-exact to `x1..x3`. After 65536 handoffs, `frame_cnt=0`.
